// File: rtl/hash_job_sequencer.sv
// Host-side job sequencer for the hashing module: start/abort, attempt counting, termination status.
// Optional watchdog on WAIT built when HASH_JOB_TIMEOUT_EN is defined.
module hash_job_sequencer #(
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               job_start,
    input  logic               job_abort,
    input  logic [NONCE_W-1:0] nonce_limit,
    input  logic               hash_done,
    input  logic               valid_hash,
    output logic               begin_hash,
    output logic               quit_hash,
    output logic               busy,
    output logic [NONCE_W-1:0] attempts,
    output logic [2:0]         status,
    output logic               job_done
);

    // Pulse protocol: job_start/job_abort/begin_hash/quit_hash/job_done are single-cycle
    // strobes with no back-pressure; hash_done is level, and only its rising edge counts.
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_QUIT} state_t;

    localparam logic [2:0] ST_NONE      = 3'd0;
    localparam logic [2:0] ST_FOUND     = 3'd1;
    localparam logic [2:0] ST_EXHAUSTED = 3'd2;
    localparam logic [2:0] ST_ABORTED   = 3'd3;
    localparam logic [2:0] ST_TIMEOUT   = 3'd4;

    state_t             state, next_state;
    logic [NONCE_W-1:0] limit_q;
    logic [NONCE_W-1:0] attempts_inc;
    logic               hash_done_d;
    logic               rise;
    logic               term;
    logic [2:0]         term_code;
    logic               wdog_expire;

    assign rise         = hash_done & ~hash_done_d;
    assign attempts_inc = attempts + NONCE_W'(1);

`ifdef HASH_JOB_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES);
    logic [WDOG_W-1:0] wdog;

    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdog <= '0;
        end else if ((state != S_WAIT) || rise) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WDOG_W'(1);
        end
    end

    assign wdog_expire = (state == S_WAIT) && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        term       = 1'b0;
        term_code  = ST_NONE;
        case (state)
            S_IDLE: begin
                if (job_start) next_state = S_START;
            end
            S_START: begin
                next_state = S_WAIT;
                if (job_abort) begin
                    next_state = S_QUIT;
                    term       = 1'b1;
                    term_code  = ST_ABORTED;
                end
            end
            S_WAIT: begin
                // Termination causes in priority order.
                if (rise && valid_hash) begin
                    next_state = S_QUIT;
                    term       = 1'b1;
                    term_code  = ST_FOUND;
                end else if (rise && (limit_q != '0) && (attempts_inc == limit_q)) begin
                    next_state = S_QUIT;
                    term       = 1'b1;
                    term_code  = ST_EXHAUSTED;
                end else if (job_abort) begin
                    next_state = S_QUIT;
                    term       = 1'b1;
                    term_code  = ST_ABORTED;
                end else if (wdog_expire) begin
                    next_state = S_QUIT;
                    term       = 1'b1;
                    term_code  = ST_TIMEOUT;
                end
            end
            S_QUIT: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        begin_hash = (state == S_START);
        quit_hash  = (state == S_QUIT);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            limit_q     <= '0;
            attempts    <= '0;
            status      <= ST_NONE;
            hash_done_d <= 1'b0;
            job_done    <= 1'b0;
        end else begin
            hash_done_d <= hash_done;
            job_done    <= (state == S_QUIT);
            if ((state == S_IDLE) && job_start) begin
                limit_q  <= nonce_limit;
                attempts <= '0;
                status   <= ST_NONE;
            end else begin
                if ((state == S_WAIT) && rise) attempts <= attempts_inc;
                if (term) status <= term_code;
            end
        end
    end

endmodule

// File: tb/tb_hash_job_sequencer.sv
// Directed bench for hash_job_sequencer; watchdog step depends on HASH_JOB_TIMEOUT_EN.
module tb_hash_job_sequencer;

    logic        clk;
    logic        n_rst;
    logic        job_start;
    logic        job_abort;
    logic [31:0] nonce_limit;
    logic        hash_done;
    logic        valid_hash;
    logic        begin_hash;
    logic        quit_hash;
    logic        busy;
    logic [31:0] attempts;
    logic [2:0]  status;
    logic        job_done;

    int errors = 0;
    int checks = 0;

    hash_job_sequencer #(
        .NONCE_W        (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .job_start   (job_start),
        .job_abort   (job_abort),
        .nonce_limit (nonce_limit),
        .hash_done   (hash_done),
        .valid_hash  (valid_hash),
        .begin_hash  (begin_hash),
        .quit_hash   (quit_hash),
        .busy        (busy),
        .attempts    (attempts),
        .status      (status),
        .job_done    (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the DUT in its START cycle.
    task automatic start_job(input logic [31:0] lim);
        job_start   = 1'b1;
        nonce_limit = lim;
        tick();
        job_start   = 1'b0;
    endtask

    // One-cycle hash_done high; returns right after the edge that sees the rise.
    task automatic rise_pulse(input logic valid);
        hash_done  = 1'b1;
        valid_hash = valid;
        tick();
        hash_done  = 1'b0;
        valid_hash = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_rst       = 1'b0;
        job_start   = 1'b0;
        job_abort   = 1'b0;
        nonce_limit = '0;
        hash_done   = 1'b0;
        valid_hash  = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_begin", 32'(begin_hash), 0);
        chk("rst_quit", 32'(quit_hash), 0);
        chk("rst_job_done", 32'(job_done), 0);
        chk("rst_attempts", attempts, 0);
        chk("rst_status", 32'(status), 0);
        n_rst = 1'b1;
        tick();

        // limit=3, three invalid rises -> exhausted
        start_job(3);
        chk("t1_begin", 32'(begin_hash), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_status0", 32'(status), 0);
        tick();
        chk("t1_begin_once", 32'(begin_hash), 0);
        rise_pulse(1'b0);
        tick();
        rise_pulse(1'b0);
        tick();
        chk("t1_attempts2", attempts, 2);
        chk("t1_no_quit", 32'(quit_hash), 0);
        rise_pulse(1'b0);
        chk("t1_quit", 32'(quit_hash), 1);
        chk("t1_attempts3", attempts, 3);
        chk("t1_status", 32'(status), 2);
        chk("t1_busy_quit", 32'(busy), 1);
        tick();
        chk("t1_quit_once", 32'(quit_hash), 0);
        chk("t1_job_done", 32'(job_done), 1);
        chk("t1_idle", 32'(busy), 0);
        tick();
        chk("t1_job_done_once", 32'(job_done), 0);
        chk("t1_status_hold", 32'(status), 2);
        chk("t1_attempts_hold", attempts, 3);

        // limit=5, held hash_done counts once, job_start in WAIT ignored, valid on second rise
        start_job(5);
        tick();
        hash_done = 1'b1;
        tick();
        tick();
        tick();
        hash_done = 1'b0;
        tick();
        chk("t2_held_once", attempts, 1);
        job_start   = 1'b1;
        nonce_limit = 1;
        tick();
        job_start   = 1'b0;
        chk("t2_start_ignored", 32'(begin_hash), 0);
        chk("t2_busy", 32'(busy), 1);
        rise_pulse(1'b1);
        chk("t2_quit", 32'(quit_hash), 1);
        chk("t2_status", 32'(status), 1);
        chk("t2_attempts", attempts, 2);
        tick();
        chk("t2_job_done", 32'(job_done), 1);
        tick();

        // unlimited job, abort about 10 cycles into WAIT
        start_job(0);
        tick();
        rise_pulse(1'b0);
        tick();
        rise_pulse(1'b0);
        tick();
        repeat (4) tick();
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t3_quit", 32'(quit_hash), 1);
        chk("t3_status", 32'(status), 3);
        chk("t3_attempts", attempts, 2);
        tick();
        chk("t3_busy_low", 32'(busy), 0);
        chk("t3_job_done", 32'(job_done), 1);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t3_idle_abort_busy", 32'(busy), 0);
        chk("t3_idle_abort_quit", 32'(quit_hash), 0);
        chk("t3_idle_abort_status", 32'(status), 3);
        tick();

        // limit=1, valid rise coincident with abort -> found wins
        start_job(1);
        tick();
        hash_done  = 1'b1;
        valid_hash = 1'b1;
        job_abort  = 1'b1;
        tick();
        hash_done  = 1'b0;
        valid_hash = 1'b0;
        job_abort  = 1'b0;
        chk("t4_quit", 32'(quit_hash), 1);
        chk("t4_status", 32'(status), 1);
        chk("t4_attempts", attempts, 1);
        tick();
        tick();

        // abort during START
        start_job(4);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t5_quit", 32'(quit_hash), 1);
        chk("t5_status", 32'(status), 3);
        chk("t5_attempts", attempts, 0);
        tick();
        chk("t5_job_done", 32'(job_done), 1);
        tick();

        // no hash_done at all in WAIT
        start_job(0);
        tick();
`ifdef HASH_JOB_TIMEOUT_EN
        repeat (15) tick();
        chk("t6_no_quit_yet", 32'(quit_hash), 0);
        chk("t6_busy", 32'(busy), 1);
        tick();
        chk("t6_quit", 32'(quit_hash), 1);
        chk("t6_status", 32'(status), 4);
        tick();
        chk("t6_job_done", 32'(job_done), 1);
        tick();
`else
        repeat (40) tick();
        chk("t6_no_timeout_quit", 32'(quit_hash), 0);
        chk("t6_busy", 32'(busy), 1);
        job_abort = 1'b1;
        tick();
        job_abort = 1'b0;
        chk("t6_status", 32'(status), 3);
        tick();
        tick();
`endif

        // reset mid-WAIT, then limit=2 job
        start_job(2);
        tick();
        rise_pulse(1'b0);
        tick();
        chk("t7_attempts_pre", attempts, 1);
        n_rst = 1'b0;
        #2;
        chk("t7_rst_busy", 32'(busy), 0);
        chk("t7_rst_attempts", attempts, 0);
        chk("t7_rst_status", 32'(status), 0);
        chk("t7_rst_quit", 32'(quit_hash), 0);
        chk("t7_rst_begin", 32'(begin_hash), 0);
        chk("t7_rst_job_done", 32'(job_done), 0);
        tick();
        n_rst = 1'b1;
        tick();
        chk("t7_no_quit_after_rst", 32'(quit_hash), 0);
        start_job(2);
        tick();
        rise_pulse(1'b0);
        tick();
        rise_pulse(1'b0);
        chk("t7_quit", 32'(quit_hash), 1);
        chk("t7_status", 32'(status), 2);
        chk("t7_attempts", attempts, 2);
        tick();
        chk("t7_job_done", 32'(job_done), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
